bram_bit_reader: RTL and testbench
==================================

Name: bram_bit_reader

Overview:
- Read-side engine for the 8192x1 dual-port block RAM (bit buffer). The write side fills the RAM one bit per cycle through port A.
- This block drives the opposite port (B) and fetches a run of bits starting at a given address. It packs them into bytes and presents them on a valid/ready byte stream toward the MAC/transmit path.
- It absorbs the RAM's 1-cycle read latency and handles output back-pressure without losing or duplicating bits.

Parameters:
ADDR_W, 13, RAM address width; depth = 2**ADDR_W bits
LEN_W, 14, width of bit_len; must be ADDR_W+1 so that a full-depth read (8192 bits) is expressible

Ports:
clk  in  1  single clock; also drives RAM port-B clock
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle request; sampled only when busy=0
start_addr  in  ADDR_W  first bit address
bit_len  in  LEN_W  number of bits to read (0..2**ADDR_W)
busy  out  1  high from cycle after accepted start until done
done  out  1  1-cycle pulse after the last byte is accepted
mem_addr  out  ADDR_W  port-B address (to addrb)
mem_dout  in  1  port-B read data (from dob); valid 1 cycle after mem_addr
m_data  out  8  output byte
m_valid  out  1  byte valid
m_ready  in  1  downstream accept
m_last  out  1  qualifies the final byte of the run

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: busy=0, done=0, m_valid=0, m_last=0, m_data=0, mem_addr=0; FSM in IDLE; all counters cleared.
- Reset asserted mid-run aborts immediately. No done pulse is produced. Partial bytes are discarded.
- FSM states: IDLE, FETCH, DRAIN, FIN.
- IDLE -> FETCH on start with bit_len!=0:
  - latch start_addr into the address counter;
  - latch bit_len into the remaining-issue and remaining-capture counters.
- IDLE -> FIN on start with bit_len==0. No byte is emitted. done pulses the following cycle.
- FETCH:
  - Issue one read per cycle (mem_addr = current address; increment modulo 2**ADDR_W) while issue is allowed.
  - A read is allowed when remaining-issue>0 AND the returning bit can be absorbed. A bit cannot be absorbed when it completes a byte, or is the run's last bit, while the output register holds an unaccepted byte (m_valid=1 && m_ready=0).
  - When issue stalls, mem_addr holds its value. This is harmless because RAM reads are non-destructive.
  - Captured bit (the cycle after issue) shifts into an 8-bit pack register.
  - Packing order: first bit read goes to m_data[0] (LSB-first, Ethernet bit order).
- Byte completion occurs on the 8th captured bit or on the run's last bit.
  - The pack register transfers to m_data; m_valid=1.
  - m_last=1 iff this byte contains the final bit.
  - A short final byte is zero-padded in the unused upper bits.
- FETCH -> DRAIN when remaining-issue reaches 0.
- DRAIN: capture the outstanding bit and wait for the final byte's handshake. Then go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Output register: m_data and m_last are held stable while m_valid=1 && m_ready=0.
  - A byte completing in the same cycle as acceptance of the previous byte loads directly, so there is no bubble.
- Throughput: with m_ready tied 1, one bit per clk. First m_valid appears 9 cycles after start for runs of 8 or more bits (1 cycle start latch, 8 fetch cycles with capture pipelined, +1 RAM latency absorbed).
- Wrap-around: a run crossing address 2**ADDR_W-1 continues at 0.
- A run of bit_len=2**ADDR_W reads every bit once, starting and ending adjacent to start_addr.
- start while busy=1 is ignored. No error flag is raised.

Optional Feature:
BRAM_RD_MSB_FIRST_EN
- Defined: the first bit of each byte lands in m_data[7] (MSB-first). A zero-padded short final byte is left-aligned, i.e. padding occupies the low bits.
- Undefined (default): LSB-first packing as described above.

Test Plan:
- RAM preloaded 0x0000..0x000F with bits 1,0,1,1,0,0,0,0, 1,1,1,1,0,0,0,0; start_addr=0, bit_len=16, m_ready=1 -> bytes 0x0D then 0x0F; m_last set only on 2nd; done pulses once; first m_valid 9 cycles after start.
- Same data, m_ready toggled 1 cycle high / 3 low -> identical 0x0D,0x0F sequence; m_data stable during stalls; no address skipped (monitor mem_addr/capture).
- start_addr=0x1FFC, bit_len=8, bits at 0x1FFC..0x1FFF=1 and 0x0000..0x0003=0 -> single byte 0x0F with m_last=1; mem_addr wraps 0x1FFF->0x0000.
- bit_len=11 with all-ones bits -> 0xFF then 0x07 (m_last=1); under BRAM_RD_MSB_FIRST_EN -> 0xFF then 0xE0.
- bit_len=0 -> no m_valid; done one cycle after start. start during busy -> ignored; the run in progress completes unchanged.
- rst_n low for 1 cycle mid-run after 2 bytes -> m_valid=0, busy=0 asynchronously; no done pulse; a fresh start then works normally.

Source files
------------

// File: rtl/bram_bit_reader_if.sv
// rtl/bram_bit_reader_if.sv - control, RAM port-B and byte-stream signals of the bit reader
interface bram_bit_reader_if #(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 14
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  bit_len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_dout;
  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    input  start, start_addr, bit_len, mem_dout, m_ready,
    output busy, done, mem_addr, m_data, m_valid, m_last
  );

  modport slave (
    output start, start_addr, bit_len, mem_dout, m_ready,
    input  busy, done, mem_addr, m_data, m_valid, m_last
  );
endinterface

// File: rtl/bram_bit_reader.sv
// rtl/bram_bit_reader.sv - port-B bit fetcher packing RAM bits into a valid/ready byte stream
// BRAM_RD_MSB_FIRST_EN: first bit of each byte goes to bit 7 (default: bit 0).
module bram_bit_reader #(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 14
) (
  input logic               clk,
  input logic               rst_n,
  bram_bit_reader_if.master rd
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  iss_rem_q, iss_rem_d;
  logic [LEN_W-1:0]  cap_rem_q, cap_rem_d;
  logic              pend_q, pend_d;
  logic              hold_v_q, hold_v_d;
  logic              hold_b_q, hold_b_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        pack_q, pack_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  logic              src_v;
  logic              src_b;
  logic              completes;
  logic              out_blocked;
  logic              cap_fire;
  logic              issue_fire;
  logic [7:0]        pack_nx;

  // A bit that cannot be absorbed parks in the hold register, so the RAM
  // output is free to move on; issue pauses until the parked bit drains.
  always_comb begin
    src_v       = pend_q | hold_v_q;
    src_b       = hold_v_q ? hold_b_q : rd.mem_dout;
    completes   = (bit_cnt_q == 3'd7) || (cap_rem_q == LEN_W'(1));
    out_blocked = valid_q && !rd.m_ready;
    cap_fire    = src_v && !(completes && out_blocked);
    issue_fire  = (state_q == S_FETCH) && (iss_rem_q != '0) && !(src_v && !cap_fire);
`ifdef BRAM_RD_MSB_FIRST_EN
    pack_nx     = pack_q | ({7'd0, src_b} << (3'd7 - bit_cnt_q));
`else
    pack_nx     = pack_q | ({7'd0, src_b} << bit_cnt_q);
`endif
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    iss_rem_d = iss_rem_q;
    cap_rem_d = cap_rem_q;
    pend_d    = 1'b0;
    hold_v_d  = 1'b0;
    hold_b_d  = hold_b_q;
    bit_cnt_d = bit_cnt_q;
    pack_d    = pack_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;

    if (valid_q && rd.m_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rd.start) begin
          if (rd.bit_len == '0) begin
            state_d = S_FIN;
          end else begin
            state_d   = S_FETCH;
            addr_d    = rd.start_addr;
            iss_rem_d = rd.bit_len;
            cap_rem_d = rd.bit_len;
          end
        end
      end
      S_FETCH, S_DRAIN: begin
        if (issue_fire) begin
          addr_d    = addr_q + ADDR_W'(1);
          iss_rem_d = iss_rem_q - LEN_W'(1);
          if (iss_rem_q == LEN_W'(1)) state_d = S_DRAIN;
        end
        pend_d   = issue_fire;
        hold_v_d = src_v && !cap_fire;
        hold_b_d = src_b;
        if (cap_fire) begin
          cap_rem_d = cap_rem_q - LEN_W'(1);
          if (completes) begin
            data_d    = pack_nx;
            valid_d   = 1'b1;
            last_d    = (cap_rem_q == LEN_W'(1));
            pack_d    = 8'd0;
            bit_cnt_d = 3'd0;
          end else begin
            pack_d    = pack_nx;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        // The final byte can only be loaded after the last issue, i.e. in DRAIN.
        if (state_q == S_DRAIN && valid_q && rd.m_ready && last_q) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      iss_rem_q <= '0;
      cap_rem_q <= '0;
      pend_q    <= 1'b0;
      hold_v_q  <= 1'b0;
      hold_b_q  <= 1'b0;
      bit_cnt_q <= 3'd0;
      pack_q    <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      iss_rem_q <= iss_rem_d;
      cap_rem_q <= cap_rem_d;
      pend_q    <= pend_d;
      hold_v_q  <= hold_v_d;
      hold_b_q  <= hold_b_d;
      bit_cnt_q <= bit_cnt_d;
      pack_q    <= pack_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

  assign rd.busy     = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign rd.done     = (state_q == S_FIN);
  assign rd.mem_addr = addr_q;
  assign rd.m_data   = data_q;
  assign rd.m_valid  = valid_q;
  assign rd.m_last   = last_q;
endmodule

// File: tb/tb_bram_bit_reader.sv
// tb/tb_bram_bit_reader.sv - randomized self-checking bench for bram_bit_reader with a byte-level reference model
module tb_bram_bit_reader;
  localparam int DEPTH = 8192;
`ifdef BRAM_RD_MSB_FIRST_EN
  localparam logic [7:0] T1_B0 = 8'hB0, T1_B1 = 8'hF0, WRAP_B = 8'hF0, T4_B1 = 8'hE0;
`else
  localparam logic [7:0] T1_B0 = 8'h0D, T1_B1 = 8'h0F, WRAP_B = 8'h0F, T4_B1 = 8'h07;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bram_bit_reader_if #(.ADDR_W(13), .LEN_W(14)) rd ();

  bram_bit_reader #(.ADDR_W(13), .LEN_W(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rd    (rd)
  );

  logic       mem [0:DEPTH-1];
  logic [7:0] exp_data [$];
  logic       exp_last [$];
  logic [7:0] rx_q [$];
  int n_checks = 0;
  int n_errors = 0;
  int done_cnt, valid_cnt, hs_cnt;
  int ready_mode = 0;
  int rdy_ph = 0;
  bit wrap_seen = 0;
  logic [12:0] prev_addr = '0;
  logic pv = 0, pr = 0, pl = 0;
  logic [7:0] pd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the run in groups of eight addresses, modulo the depth.
  task automatic build_expected(input int addr, input int len);
    exp_data.delete();
    exp_last.delete();
    for (int k = 0; k < len; k += 8) begin
      logic [7:0] b = 8'd0;
      for (int j = 0; j < 8 && k + j < len; j++) begin
`ifdef BRAM_RD_MSB_FIRST_EN
        b[7-j] = mem[(addr + k + j) % DEPTH];
`else
        b[j] = mem[(addr + k + j) % DEPTH];
`endif
      end
      exp_data.push_back(b);
      exp_last.push_back(k + 8 >= len);
    end
  endtask

  always @(posedge clk) rd.mem_dout <= mem[rd.mem_addr];

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: rd.m_ready = 1'b1;
      1: begin rd.m_ready = (rdy_ph == 0); rdy_ph = (rdy_ph + 1) % 4; end
      default: rd.m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 0;
      pr = 0;
    end else begin
      if (pv && !pr) begin
        check("stall_valid", rd.m_valid, 1);
        check("stall_data", rd.m_data, pd);
        check("stall_last", rd.m_last, pl);
      end
      if (rd.m_valid && rd.m_ready) begin
        check("byte_expected", 32'(exp_data.size() != 0), 1);
        if (exp_data.size() != 0) begin
          check("data", rd.m_data, exp_data.pop_front());
          check("last", rd.m_last, exp_last.pop_front());
        end
        rx_q.push_back(rd.m_data);
        hs_cnt++;
      end
      if (rd.done) done_cnt++;
      if (rd.m_valid) valid_cnt++;
      pv = rd.m_valid;
      pr = rd.m_ready;
      pd = rd.m_data;
      pl = rd.m_last;
    end
    if (prev_addr == 13'h1FFF && rd.mem_addr == 13'h0000) wrap_seen = 1;
    prev_addr = rd.mem_addr;
  end

  // Called at posedge+1; one start pulse, then bounded wait for done.
  task automatic run(input int addr, input int len, input int rmode, input bit inject);
    int n, lat, exp_lat;
    bit got_done;
    build_expected(addr, len);
    rx_q.delete();
    done_cnt = 0;
    valid_cnt = 0;
    hs_cnt = 0;
    ready_mode = rmode;
    exp_lat = (len == 0) ? -1 : ((len >= 8) ? 9 : len + 1);
    rd.start = 1'b1;
    rd.start_addr = 13'(addr);
    rd.bit_len = 14'(len);
    @(posedge clk); #1;
    rd.start = 1'b0;
    if (len != 0) check("busy_after_start", rd.busy, 1);
    n = 0;
    lat = -1;
    got_done = 0;
    while (n < 8 * len + 200) begin
      if (rd.m_valid && lat < 0) lat = n;
      if (rd.done) begin got_done = 1; break; end
      if (inject && n == 3) begin
        rd.start = 1'b1;
        rd.start_addr = 13'($urandom);
        rd.bit_len = 14'd5;
      end else begin
        rd.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    rd.start = 1'b0;
    check("done_seen", got_done, 1);
    if (len == 0) check("zero_done_lat", n, 0);
    if (exp_lat >= 0) check("first_valid_lat", lat, exp_lat);
    check("all_bytes", exp_data.size(), 0);
    check("busy_at_done", rd.busy, 0);
    @(posedge clk); #1;
    check("done_once", done_cnt, 1);
    check("done_low", rd.done, 0);
    if (len == 0) check("zero_no_valid", valid_cnt, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    rd.start = 1'b0;
    rd.start_addr = '0;
    rd.bit_len = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", rd.busy, 0);
    check("rst_done", rd.done, 0);
    check("rst_valid", rd.m_valid, 0);
    check("rst_last", rd.m_last, 0);
    check("rst_data", rd.m_data, 0);
    check("rst_addr", rd.mem_addr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) mem[i] = (i inside {0, 2, 3, 8, 9, 10, 11});
    run(0, 16, 0, 0);
    check("t1_count", rx_q.size(), 2);
    check("t1_b0", rx_q[0], T1_B0);
    check("t1_b1", rx_q[1], T1_B1);

    run(0, 16, 1, 0);
    check("t2_count", rx_q.size(), 2);
    check("t2_b0", rx_q[0], T1_B0);
    check("t2_b1", rx_q[1], T1_B1);

    for (int i = 0; i < 4; i++) begin mem[DEPTH - 4 + i] = 1'b1; mem[i] = 1'b0; end
    wrap_seen = 0;
    run(13'h1FFC, 8, 0, 0);
    check("wrap_count", rx_q.size(), 1);
    check("wrap_b0", rx_q[0], WRAP_B);
    check("wrap_addr", wrap_seen, 1);

    for (int i = 100; i < 111; i++) mem[i] = 1'b1;
    run(100, 11, 2, 0);
    check("t4_count", rx_q.size(), 2);
    check("t4_b0", rx_q[0], 8'hFF);
    check("t4_b1", rx_q[1], T4_B1);

    run(5, 0, 0, 0);
    run(200, 24, 1, 1);

    build_expected(300, 40);
    hs_cnt = 0;
    done_cnt = 0;
    ready_mode = 0;
    rd.start = 1'b1;
    rd.start_addr = 13'd300;
    rd.bit_len = 14'd40;
    @(posedge clk); #1;
    rd.start = 1'b0;
    n = 0;
    while (hs_cnt < 2 && n < 200) begin @(posedge clk); #1; n++; end
    check("abort_bytes_seen", 32'(hs_cnt >= 2), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", rd.m_valid, 0);
    check("abort_busy", rd.busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_data.delete();
    exp_last.delete();
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", rd.busy, 0);
    run(300, 40, 0, 0);

    for (int r = 0; r < 30; r++) begin
      int len;
      len = (r % 5 == 0) ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 48));
      run(int'($urandom_range(0, DEPTH - 1)), len, int'($urandom_range(0, 2)), 1'(r % 7 == 3 && len > 16));
    end
    run(int'($urandom_range(DEPTH - 20, DEPTH - 1)), 37, 2, 0);

    wrap_seen = 0;
    run(int'($urandom_range(0, DEPTH - 1)), DEPTH, 0, 0);
    check("full_bytes", rx_q.size(), DEPTH / 8);
    check("full_wrap", wrap_seen, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
